// File: rtl/led_ctrl_pkg.sv
// Shared types and register-map constants for the LED PWM controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } mode_t;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

  localparam int CTRL_OFF  = 'h00;
  localparam int PRESC_OFF = 'h04;
  localparam int CH_BASE   = 'h10;
  localparam int CH_STRIDE = 8;
  localparam int MODE_OFF  = 0;
  localparam int DUTY_OFF  = 4;

  function automatic int ch_reg_addr(input int ch, input int reg_off);
    return CH_BASE + CH_STRIDE * ch + reg_off;
  endfunction

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// CPU data-bus port of the LED controller.
// Handshake: the master raises mem_valid and holds it, with mem_we/mem_addr/mem_wdata
// stable, until it sees mem_ready; mem_ready is a single-cycle pulse and mem_rdata is valid with it.
interface led_pwm_ctrl_if #(
  parameter int ADDR_W = 8
);
  import led_ctrl_pkg::*;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  bus_state_t        dbg_state;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, dbg_state
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, dbg_state
  );

endinterface

// File: rtl/led_channel.sv
// One LED channel: blink half-period counter plus mode-dependent on/off decision.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  mode_t            mode,
  input  logic [PWM_W-1:0] duty,
  input  logic             tick,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic             clear,
  input  logic             en,
  output logic             on
);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    // A register write wins over a tick landing in the same cycle.
    if (!en || clear) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (tick) begin
      if (cnt_q == duty) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    on = 1'b0;
    case (mode)
      LED_OFF:   on = 1'b0;
      LED_ON:    on = 1'b1;
      LED_BLINK: on = blink_q;
      LED_PWM:   on = (pwm_cnt < duty);
      default:   on = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED controller: bus FSM, register file, shared prescaler and PWM
// counter, and one led_channel per active-low LED output.
module led_pwm_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS = 2,
  parameter int PWM_W    = 8,
  parameter int PRESC_W  = 16,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  led_pwm_ctrl_if.slave       bus,
  output logic [NUM_LEDS-1:0] led_n
);

  bus_state_t state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_word;
  logic        wr_en, rd_en;
  logic [ADDR_W-1:0] byte_a;

  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic               presc_wr, tick;
  mode_t              mode_q [NUM_LEDS];
  mode_t              mode_d [NUM_LEDS];
  logic [PWM_W-1:0]   duty_q [NUM_LEDS];
  logic [PWM_W-1:0]   duty_d [NUM_LEDS];
  logic [NUM_LEDS-1:0] ch_clear, ch_on;
  logic [NUM_LEDS-1:0] led_n_q, led_n_d;
  logic                unused_bits;

  assign byte_a      = {bus.mem_addr[ADDR_W-1:2], 2'b00};
  assign wr_en       = (state_q == BUS_IDLE) && bus.mem_valid && bus.mem_we;
  assign rd_en       = (state_q == BUS_IDLE) && bus.mem_valid && !bus.mem_we;
  assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata};

  // A request arriving during the ACK cycle is only sampled once back in IDLE.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      BUS_IDLE: begin
        if (bus.mem_valid) begin
          state_d = BUS_ACK;
          if (rd_en) rdata_d = rd_word;
        end
      end
      BUS_ACK: state_d = BUS_IDLE;
      default: state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    if (byte_a == ADDR_W'(CTRL_OFF))  rd_word[0] = en_q;
    if (byte_a == ADDR_W'(PRESC_OFF)) rd_word[PRESC_W-1:0] = presc_q;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (byte_a == ADDR_W'(ch_reg_addr(i, MODE_OFF))) rd_word[1:0] = mode_q[i];
      if (byte_a == ADDR_W'(ch_reg_addr(i, DUTY_OFF))) rd_word[PWM_W-1:0] = duty_q[i];
    end
  end

  always_comb begin
    en_d     = en_q;
    presc_d  = presc_q;
    presc_wr = 1'b0;
    ch_clear = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      mode_d[i] = mode_q[i];
      duty_d[i] = duty_q[i];
    end
    if (wr_en) begin
      if (byte_a == ADDR_W'(CTRL_OFF)) en_d = bus.mem_wdata[0];
      if (byte_a == ADDR_W'(PRESC_OFF)) begin
        presc_d  = bus.mem_wdata[PRESC_W-1:0];
        presc_wr = 1'b1;
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (byte_a == ADDR_W'(ch_reg_addr(i, MODE_OFF))) begin
          mode_d[i]   = mode_t'(bus.mem_wdata[1:0]);
          ch_clear[i] = 1'b1;
        end
        if (byte_a == ADDR_W'(ch_reg_addr(i, DUTY_OFF))) begin
          duty_d[i]   = bus.mem_wdata[PWM_W-1:0];
          ch_clear[i] = 1'b1;
        end
      end
    end
  end

  assign tick = en_q && (presc_cnt_q == presc_q);

  always_comb begin
    presc_cnt_d = presc_cnt_q + 1'b1;
    pwm_cnt_d   = pwm_cnt_q;
    if (!en_q || presc_wr || tick) presc_cnt_d = '0;
    if (!en_q)     pwm_cnt_d = '0;
    else if (tick) pwm_cnt_d = pwm_cnt_q + 1'b1;
    led_n_d = en_q ? ~ch_on : '1;
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    led_channel #(.PWM_W(PWM_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .mode    (mode_q[g]),
      .duty    (duty_q[g]),
      .tick    (tick),
      .pwm_cnt (pwm_cnt_q),
      .clear   (ch_clear[g]),
      .en      (en_q),
      .on      (ch_on[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= BUS_IDLE;
      rdata_q     <= '0;
      en_q        <= 1'b0;
      presc_q     <= '0;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      led_n_q     <= '1;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i] <= LED_OFF;
        duty_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      en_q        <= en_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      led_n_q     <= led_n_d;
      for (int i = 0; i < NUM_LEDS; i++) begin
        mode_q[i] <= mode_d[i];
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign bus.mem_ready = (state_q == BUS_ACK);
  assign bus.mem_rdata = rdata_q;
  assign bus.dbg_state = state_q;
  assign led_n         = led_n_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed + randomized bench for led_pwm_ctrl with an arithmetic LED reference model.
module tb_led_pwm_ctrl;
  import led_ctrl_pkg::*;

  localparam int NUM_LEDS = 2;
  localparam int PWM_W    = 8;
  localparam int PRESC_W  = 16;
  localparam int ADDR_W   = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NUM_LEDS-1:0] led_n;

  led_pwm_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  led_pwm_ctrl #(
    .NUM_LEDS (NUM_LEDS),
    .PWM_W    (PWM_W),
    .PRESC_W  (PRESC_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .led_n (led_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: register contents plus the cycle of enable / last channel write.
  bit m_en;
  int m_en_cyc;
  int m_presc;
  int m_mode [NUM_LEDS];
  int m_duty [NUM_LEDS];
  int m_ref  [NUM_LEDS];

  function automatic void model_reset();
    m_en = 0; m_en_cyc = 0; m_presc = 0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      m_mode[i] = 0; m_duty[i] = 0; m_ref[i] = 0;
    end
  endfunction

  function automatic int ticks_before(input int c);
    if (!m_en || c <= m_en_cyc) return 0;
    return (c - m_en_cyc) / (m_presc + 1);
  endfunction

  function automatic bit model_on(input int i, input int c);
    int r, n;
    if (!m_en) return 1'b0;
    case (m_mode[i])
      1: return 1'b1;
      2: begin
        r = (m_ref[i] > m_en_cyc) ? m_ref[i] : m_en_cyc;
        n = ticks_before(c) - ticks_before(r);
        return ((n / (m_duty[i] + 1)) % 2) == 1;
      end
      3: return (ticks_before(c) % (1 << PWM_W)) < m_duty[i];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_LEDS-1:0] model_led_next(input int c);
    logic [NUM_LEDS-1:0] v;
    for (int i = 0; i < NUM_LEDS; i++) v[i] = ~model_on(i, c);
    return v;
  endfunction

  function automatic void model_write(input int addr, input int data, input int k);
    if (addr == CTRL_OFF) begin
      if (data[0] && !m_en) begin m_en = 1; m_en_cyc = k; end
      else if (!data[0]) m_en = 0;
    end else if (addr == PRESC_OFF) begin
      m_presc = data & ((1 << PRESC_W) - 1);
    end
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (addr == ch_reg_addr(i, MODE_OFF)) begin m_mode[i] = data & 3; m_ref[i] = k; end
      if (addr == ch_reg_addr(i, DUTY_OFF)) begin m_duty[i] = data & ((1 << PWM_W) - 1); m_ref[i] = k; end
    end
  endfunction

  function automatic int model_read(input int addr);
    if (addr == CTRL_OFF)  return int'(m_en);
    if (addr == PRESC_OFF) return m_presc;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (addr == ch_reg_addr(i, MODE_OFF)) return m_mode[i];
      if (addr == ch_reg_addr(i, DUTY_OFF)) return m_duty[i];
    end
    return 0;
  endfunction

  // Continuous LED check: led_n this cycle must equal the model's decision of last cycle.
  bit chk_on = 0;
  bit primed = 0;
  logic [NUM_LEDS-1:0] exp_led;
  always @(negedge clk) begin
    if (!chk_on) begin
      primed = 0;
    end else begin
      if (primed) begin
        checks++;
        assert (led_n === exp_led) else begin
          errors++;
          $error("FAIL led_n cyc=%0d observed=%b expected=%b", cyc, led_n, exp_led);
        end
      end
      exp_led = model_led_next(cyc);
      primed = 1;
    end
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic bus_write(input int addr, input int data);
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_we = 1'b1;
    bus.mem_addr = addr[ADDR_W-1:0]; bus.mem_wdata = data;
    @(posedge clk); #1;
    check_bit("wr_ready", bus.mem_ready, 1'b1);
    model_write(addr, data, cyc);
    bus.mem_valid = 1'b0; bus.mem_we = 1'b0;
    @(posedge clk); #1;
    check_bit("wr_ready_drop", bus.mem_ready, 1'b0);
  endtask

  task automatic bus_read(input int addr, input string tag);
    logic [31:0] exp_v;
    exp_v = model_read(addr);
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = addr[ADDR_W-1:0];
    @(posedge clk); #1;
    check_bit("rd_ready", bus.mem_ready, 1'b1);
    check_word(tag, bus.mem_rdata, exp_v);
    bus.mem_valid = 1'b0;
    @(posedge clk); #1;
    check_bit("rd_ready_drop", bus.mem_ready, 1'b0);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic read_all_regs();
    bus_read(CTRL_OFF, "rd_ctrl");
    bus_read(PRESC_OFF, "rd_presc");
    for (int i = 0; i < NUM_LEDS; i++) begin
      bus_read(ch_reg_addr(i, MODE_OFF), "rd_mode");
      bus_read(ch_reg_addr(i, DUTY_OFF), "rd_duty");
    end
  endtask

  initial begin
    int lows;
    int ch;
    int md;
    bus.mem_valid = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    model_reset();

    // Reset held for two cycles
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_word("reset_led_n", {30'd0, led_n}, {30'd0, 2'b11});
    check_bit("reset_ready", bus.mem_ready, 1'b0);
    check_word("reset_rdata", bus.mem_rdata, 32'd0);
    @(negedge clk); reset = 1'b1;
    read_all_regs();

    // Basic bus access, unmapped window, unused bits
    bus_write(PRESC_OFF, 5);
    bus_read(PRESC_OFF, "rd_presc5");
    bus_read('h3C, "rd_unmapped");
    bus_write('h3C, 'hFFFF);
    bus_read('h3C, "rd_unmapped_wr");
    bus_write(CTRL_OFF, 'hFFFF_FFFE);
    bus_read(CTRL_OFF, "rd_ctrl_unused");
    bus_write(ch_reg_addr(1, DUTY_OFF), 'h1234);
    bus_read(ch_reg_addr(1, DUTY_OFF), "rd_duty_trunc");
    bus_write(ch_reg_addr(0, MODE_OFF), 'hFFFF_FFFF);
    bus_read(ch_reg_addr(0, MODE_OFF), "rd_mode_trunc");
    bus_read(ch_reg_addr(1, DUTY_OFF), "rd_hold_check");
    check_word("rdata_holds", bus.mem_rdata, 32'h34);

    // Request held through the ready cycle is accepted again only one cycle later
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = PRESC_OFF;
    @(posedge clk); #1;
    check_bit("b2b_ready1", bus.mem_ready, 1'b1);
    check_bit("b2b_dbg_ack", bus.dbg_state == BUS_ACK, 1'b1);
    @(posedge clk); #1;
    check_bit("b2b_gap", bus.mem_ready, 1'b0);
    @(posedge clk); #1;
    check_bit("b2b_ready2", bus.mem_ready, 1'b1);
    check_word("b2b_rdata", bus.mem_rdata, 32'd5);
    bus.mem_valid = 1'b0;
    @(posedge clk); #1;
    check_bit("b2b_drop", bus.mem_ready, 1'b0);

    chk_on = 1;

    // ON / OFF
    bus_write(PRESC_OFF, 0);
    bus_write(ch_reg_addr(0, MODE_OFF), 1);
    bus_write(ch_reg_addr(1, MODE_OFF), 0);
    bus_write(CTRL_OFF, 1);
    run_cycles(2); #1;
    check_word("on_off_led", {30'd0, led_n}, {30'd0, 2'b10});

    // BLINK with a mid-period duty rewrite
    bus_write(CTRL_OFF, 0);
    bus_write(ch_reg_addr(0, DUTY_OFF), 3);
    bus_write(ch_reg_addr(0, MODE_OFF), 2);
    bus_write(CTRL_OFF, 1);
    run_cycles(30);
    bus_write(ch_reg_addr(0, DUTY_OFF), 3);
    run_cycles(30);

    // PWM at duty 64, then duty 0
    bus_write(CTRL_OFF, 0);
    bus_write(ch_reg_addr(0, MODE_OFF), 0);
    bus_write(ch_reg_addr(1, DUTY_OFF), 64);
    bus_write(ch_reg_addr(1, MODE_OFF), 3);
    bus_write(CTRL_OFF, 1);
    run_cycles(10);
    lows = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_n[1] == 1'b0) lows++;
    end
    check_word("pwm64_low_count", lows, 64);
    bus_write(ch_reg_addr(1, DUTY_OFF), 0);
    run_cycles(2);
    lows = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_n[1] == 1'b0) lows++;
    end
    check_word("pwm0_low_count", lows, 0);

    // Disable while blinking, then re-enable from cleared counters
    bus_write(ch_reg_addr(0, DUTY_OFF), 1);
    bus_write(ch_reg_addr(0, MODE_OFF), 2);
    run_cycles(13);
    bus_write(CTRL_OFF, 0);
    check_word("disable_led", {30'd0, led_n}, {30'd0, 2'b11});
    run_cycles(7);
    bus_write(CTRL_OFF, 1);
    run_cycles(40);

    // Randomized configurations
    for (int r = 0; r < 6; r++) begin
      bus_write(CTRL_OFF, 0);
      bus_write(PRESC_OFF, $urandom_range(0, 3));
      for (int i = 0; i < NUM_LEDS; i++) begin
        md = $urandom_range(0, 3);
        bus_write(ch_reg_addr(i, MODE_OFF), md);
        bus_write(ch_reg_addr(i, DUTY_OFF), (md == 2) ? $urandom_range(0, 7) : $urandom_range(0, 255));
      end
      bus_write(CTRL_OFF, 1);
      run_cycles($urandom_range(100, 300));
      ch = $urandom_range(0, NUM_LEDS - 1);
      if ($urandom_range(0, 1) == 1) bus_write(ch_reg_addr(ch, DUTY_OFF), $urandom_range(0, 7));
      else bus_write(ch_reg_addr(ch, MODE_OFF), $urandom_range(0, 3));
      run_cycles($urandom_range(100, 300));
      read_all_regs();
    end

    // Reset during a pending read: no ready, everything cleared
    chk_on = 0;
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = PRESC_OFF;
    reset = 1'b0;
    @(posedge clk); #1;
    check_bit("rst_abort_ready", bus.mem_ready, 1'b0);
    bus.mem_valid = 1'b0;
    @(posedge clk); #1;
    check_bit("rst_abort_ready2", bus.mem_ready, 1'b0);
    check_word("rst_abort_led", {30'd0, led_n}, {30'd0, 2'b11});
    @(negedge clk); reset = 1'b1;
    model_reset();
    read_all_regs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
